// File: rtl/rdback_serializer.sv
// rdback_serializer: drains DQ_WIDTH*4-bit read-back FIFO entries and
// streams each one to the host as 32-bit words, least-significant word first.
// Optional build macro RDBACK_SEQ_HDR_EN prefixes every entry with a header
// word {16'h5EC0, seq[15:0]} carrying a free-running sequence number.
module rdback_serializer #(
    parameter int DQ_WIDTH = 64,
    parameter int TCQ      = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdback_fifo_empty,
    output logic                    rdback_fifo_rden,
    input  logic [DQ_WIDTH*4-1:0]   rdback_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [31:0]             tx_data,
    output logic                    tx_last,
    output logic                    busy
);

    localparam int ENTRY_W = DQ_WIDTH * 4;
    localparam int NW      = ENTRY_W / 32;
    localparam int BEAT_W  = ($clog2(NW) > 4) ? $clog2(NW) : 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NW - 1);

    // Entry width must split into whole 32-bit words; TCQ is a modelling
    // delay only and has no effect on the synthesized logic.
    if ((ENTRY_W % 32) != 0 || TCQ < 0) begin : g_param_check
        $error("rdback_serializer: DQ_WIDTH*4 must be a multiple of 32");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND
`ifdef RDBACK_SEQ_HDR_EN
        , S_HDR
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   shift_q, shift_d;
    logic [BEAT_W-1:0]    beat_q,  beat_d;
`ifdef RDBACK_SEQ_HDR_EN
    logic [15:0]          seq_q,   seq_d;
`endif

    // State, shift register, beat counter (and sequence counter) registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            beat_q  <= '0;
`ifdef RDBACK_SEQ_HDR_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            beat_q  <= beat_d;
`ifdef RDBACK_SEQ_HDR_EN
            seq_q   <= seq_d;
`endif
        end
    end

    // Next-state and output decode; outputs are a pure function of state
    // so tx_data/tx_last stay frozen while the host withholds tx_ready.
    always_comb begin
        state_d          = state_q;
        shift_d          = shift_q;
        beat_d           = beat_q;
`ifdef RDBACK_SEQ_HDR_EN
        seq_d            = seq_q;
`endif
        rdback_fifo_rden = 1'b0;
        tx_valid         = 1'b0;
        tx_last          = 1'b0;
        tx_data          = '0;

        case (state_q)
            S_IDLE: begin
                // Read only when the FIFO has an entry and reset is released.
                if (!rdback_fifo_empty && !rst) begin
                    rdback_fifo_rden = 1'b1;
                    state_d          = S_FETCH;
                end
            end
            S_FETCH: begin
                // FIFO dout becomes valid one cycle after the read strobe.
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = rdback_data;
                beat_d  = '0;
`ifdef RDBACK_SEQ_HDR_EN
                state_d = S_HDR;
`else
                state_d = S_SEND;
`endif
            end
`ifdef RDBACK_SEQ_HDR_EN
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = {16'h5EC0, seq_q};
                if (tx_ready) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = S_SEND;
                end
            end
`endif
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[31:0];
                tx_last  = (beat_q == LAST_BEAT);
                if (tx_ready) begin
                    shift_d = shift_q >> 32;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_rdback_serializer.sv
// Directed testbench for rdback_serializer at DQ_WIDTH=64 (8 words/entry).
module tb_rdback_serializer;

    localparam int DQ_WIDTH = 64;
    localparam int NW       = DQ_WIDTH * 4 / 32;
`ifdef RDBACK_SEQ_HDR_EN
    localparam int WPE      = NW + 1;
`else
    localparam int WPE      = NW;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rdback_fifo_empty;
    logic                  rdback_fifo_rden;
    logic [DQ_WIDTH*4-1:0] rdback_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [31:0]           tx_data;
    logic                  tx_last;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DQ_WIDTH*4-1:0] fifo_mem[$];
    int fifo_cnt    = 0;
    int rden_count  = 0;
    int rden_bad    = 0;
    int cyc         = 0;
`ifdef RDBACK_SEQ_HDR_EN
    int seq_next    = 0;
`endif

    logic [31:0] got_data[$];
    bit          got_last[$];
    int          got_cycle[$];

    rdback_serializer #(.DQ_WIDTH(DQ_WIDTH), .TCQ(100)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdback_fifo_empty(rdback_fifo_empty),
        .rdback_fifo_rden (rdback_fifo_rden),
        .rdback_data      (rdback_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .tx_last          (tx_last),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    assign rdback_fifo_empty = (fifo_cnt == 0);

    // FIFO model: dout appears the cycle after a read strobe.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rdback_fifo_rden) begin
            rden_count = rden_count + 1;
            if (busy || rst || fifo_cnt == 0) rden_bad = rden_bad + 1;
            if (fifo_cnt > 0) begin
                rdback_data <= fifo_mem.pop_front();
                fifo_cnt = fifo_cnt - 1;
            end
        end
    end

    // Word j of entry id: id*0x100 + 0x11111111*j (entry 0 gives 32'h1111_1111*k).
    task automatic push_entry(input int id);
        logic [DQ_WIDTH*4-1:0] v;
        for (int k = 0; k < NW; k++) v[32*k +: 32] = 32'(id) * 32'h100 + 32'h1111_1111 * 32'(k);
        fifo_mem.push_back(v);
        fifo_cnt = fifo_cnt + 1;
    endtask

    function automatic logic [31:0] exp_word(input int first_id, input int i);
        int e;
        int j;
        e = first_id + i / WPE;
        j = i % WPE;
`ifdef RDBACK_SEQ_HDR_EN
        if (j == 0) return {16'h5EC0, 16'(seq_next + i / WPE)};
        j = j - 1;
`endif
        return 32'(e) * 32'h100 + 32'h1111_1111 * 32'(j);
    endfunction

    // Collects nw accepted words. mode 0: tx_ready=1; mode 1: 1,0,0,1 pattern.
    task automatic collect(input int nw, input int mode, input int budget);
        int k;
        logic pv, pr, pl;
        logic [31:0] pd;
        k = 0; pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        got_data.delete(); got_last.delete(); got_cycle.delete();
        for (int c = 0; c < budget && got_data.size() < nw; c++) begin
            @(negedge clk);
            tx_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            k++;
            if (pv && !pr) begin
                n_checks++;
                if (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                             tx_valid, tx_data, tx_last, pd, pl);
                end
            end
            if (tx_valid && tx_ready) begin
                got_data.push_back(tx_data);
                got_last.push_back(tx_last);
                got_cycle.push_back(cyc);
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
        end
        n_checks++;
        if (got_data.size() != nw) begin
            n_fail++;
            $display("FAIL collect_timeout: got %0d words, expected %0d", got_data.size(), nw);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rdback_fifo_rden, tx_valid, tx_last, busy} !== 4'b0000 || tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got rden=%b valid=%b last=%b busy=%b data=%h, expected all 0",
                     rdback_fifo_rden, tx_valid, tx_last, busy, tx_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_empty();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_checks++;
            if (rdback_fifo_rden !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_idle[%0d]: got rden=%b valid=%b busy=%b, expected 0 0 0",
                         c, rdback_fifo_rden, tx_valid, busy);
            end
        end
    endtask

    task automatic test_single();
        int r0;
        r0 = rden_count;
        push_entry(0);
        collect(WPE, 0, 200);
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_word(0, i) || got_last[i] !== (i % WPE == WPE - 1)) begin
                n_fail++;
                $display("FAIL single_word[%0d]: got %h last=%b, expected %h last=%b",
                         i, got_data[i], got_last[i], exp_word(0, i), (i % WPE == WPE - 1));
            end
        end
`ifdef RDBACK_SEQ_HDR_EN
        seq_next = seq_next + 1;
`endif
        repeat (5) @(negedge clk);
        n_checks++;
        if (rden_count - r0 != 1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rden: got %0d pulses valid=%b busy=%b, expected 1 pulse, 0, 0",
                     rden_count - r0, tx_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rden_count;
        push_entry(1); push_entry(2); push_entry(3);
        collect(3 * WPE, 0, 400);
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_word(1, i) || got_last[i] !== (i % WPE == WPE - 1)) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got %h last=%b, expected %h last=%b",
                         i, got_data[i], got_last[i], exp_word(1, i), (i % WPE == WPE - 1));
            end
        end
        for (int e = 1; e < 3 && got_cycle.size() == 3 * WPE; e++) begin
            n_checks++;
            if (got_cycle[e * WPE] - got_cycle[e * WPE - 1] != 4) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: got %0d cycles between words, expected 4",
                         e, got_cycle[e * WPE] - got_cycle[e * WPE - 1]);
            end
        end
`ifdef RDBACK_SEQ_HDR_EN
        seq_next = seq_next + 3;
`endif
        n_checks++;
        if (rden_count - r0 != 3) begin
            n_fail++;
            $display("FAIL b2b_rden: got %0d pulses, expected 3", rden_count - r0);
        end
    endtask

    task automatic test_backpressure();
        push_entry(4);
        collect(WPE, 1, 300);
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_word(4, i) || got_last[i] !== (i % WPE == WPE - 1)) begin
                n_fail++;
                $display("FAIL bp_word[%0d]: got %h last=%b, expected %h last=%b",
                         i, got_data[i], got_last[i], exp_word(4, i), (i % WPE == WPE - 1));
            end
        end
`ifdef RDBACK_SEQ_HDR_EN
        seq_next = seq_next + 1;
`endif
    endtask

    task automatic test_reset_mid();
        int r0;
        r0 = rden_count;
        push_entry(5); push_entry(6);
        collect(4, 0, 200);
        @(negedge clk);
        rst = 1'b1; tx_ready = 1'b0;
        n_checks++;
        if (rdback_fifo_rden !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rden: got %b, expected 0", rdback_fifo_rden);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_last !== 1'b0 || busy !== 1'b0 || tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got valid=%b last=%b busy=%b data=%h, expected 0 0 0 0",
                     tx_valid, tx_last, busy, tx_data);
        end
`ifdef RDBACK_SEQ_HDR_EN
        seq_next = 0;
`endif
        collect(WPE, 0, 200);
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_word(6, i) || got_last[i] !== (i % WPE == WPE - 1)) begin
                n_fail++;
                $display("FAIL rst_next_word[%0d]: got %h last=%b, expected %h last=%b",
                         i, got_data[i], got_last[i], exp_word(6, i), (i % WPE == WPE - 1));
            end
        end
`ifdef RDBACK_SEQ_HDR_EN
        seq_next = seq_next + 1;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (rden_count - r0 != 2 || rden_bad != 0) begin
            n_fail++;
            $display("FAIL rst_rden_count: got %0d pulses (%0d illegal), expected 2 (0 illegal)",
                     rden_count - r0, rden_bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_ready = 1'b0;
        rdback_data = '0;
        test_reset();
        test_empty();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
